// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, parity-type constants and default width.
// Used by the TX frame generator and the parity helper that the RX side also uses.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity: XOR-reduce of a data word with odd/even selection.
// Shared between the UART TX frame generator and the RX parity checker.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_type,
    output logic                  parity
);

    assign parity = (^data) ^ (par_type == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to stretch the stop phase to two bit times.
module uart_tx_frame_gen
    import uart_pkg::*;
#(
    parameter int   DATA_WIDTH = UART_DATA_WIDTH,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    // Handshake: data_valid is sampled only in IDLE; the accepting edge is the one
    // where state_q==ST_IDLE and data_valid==1, and busy rises on that same edge.
    uart_tx_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  parity_bit;
    logic                  tx_d;
    logic                  busy_d;
    logic                  accept;

`ifdef UART_TX_TWO_STOP_EN
    logic stop_cnt_q;
`endif

    assign accept = (state_q == ST_IDLE) && data_valid;

    // The shift register rotates, so its XOR-reduce always equals the captured byte's.
    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (shift_q),
        .par_type(par_type_q),
        .parity  (parity_bit)
    );

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tx_out  <= IDLE_LEVEL;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_out  <= tx_d;
            busy    <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
        end else begin
            if (accept) begin
                shift_q    <= data_in;
                par_en_q   <= par_en;
                par_type_q <= par_type;
            end else if (state_d == ST_DATA) begin
                shift_q <= {shift_q[0], shift_q[DATA_WIDTH-1:1]};
            end
            if (state_q == ST_DATA) begin
                cnt_q <= (state_d == ST_DATA) ? cnt_q + 1'b1 : '0;
            end
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_cnt_q <= 1'b0;
        end else if (state_q == ST_STOP) begin
            stop_cnt_q <= ~stop_cnt_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (data_valid) state_d = ST_START;
            ST_START:  state_d = ST_DATA;
            ST_DATA:   if (cnt_q == CNT_LAST) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: state_d = ST_STOP;
`ifdef UART_TX_TWO_STOP_EN
            ST_STOP:   if (stop_cnt_q) state_d = ST_IDLE;
`else
            ST_STOP:   state_d = ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered, so the line changes on the entering edge.
    always_comb begin
        tx_d   = IDLE_LEVEL;
        busy_d = (state_d != ST_IDLE);
        unique case (state_d)
            ST_START:  tx_d = ~IDLE_LEVEL;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = parity_bit;
            default:   tx_d = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Self-checking bench for uart_tx_frame_gen: directed and random frames against a bit-list model.
// Honours UART_TX_TWO_STOP_EN when building expected frames.
module tb_uart_tx_frame_gen;

    localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         par_en = 1'b0;
    logic         par_type = 1'b0;
    logic         tx_out;
    logic         busy;

    uart_tx_frame_gen #(.DATA_WIDTH(W), .IDLE_LEVEL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .par_en    (par_en),
        .par_type  (par_type),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame as a list of line levels, one per bit time.
    function automatic void build_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                                        output logic [15:0] bits, output int len);
        int k;
        bits = '0;
        k = 0;
        bits[4'(k)] = 1'b0;
        k++;
        for (int i = 0; i < W; i++) begin
            bits[4'(k)] = d[i];
            k++;
        end
        if (pe) begin
            int ones = 0;
            for (int i = 0; i < W; i++) ones += int'(d[i]);
            bits[4'(k)] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
            k++;
        end
        for (int s = 0; s < STOP_BITS; s++) begin
            bits[4'(k)] = 1'b1;
            k++;
        end
        len = k;
    endfunction

    // Scoreboard
    logic [15:0] exp_q[$];
    int          exp_len_q[$];
    int          n_sent = 0;

    // Monitor: collects the line while busy, compares each finished frame.
    logic [15:0] cap = '0;
    int          cap_len = 0;
    int          gap = 0;
    bit          check_gap = 0;
    bit          seen_frame = 0;
    int          idle_bad = 0;
    int          frames_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cap_len = 0;
            gap = 0;
            seen_frame = 0;
        end else if (busy) begin
            if (cap_len == 0) begin
                if (check_gap && seen_frame) check("idle_gap", gap, 1);
                cap = '0;
            end
            if (cap_len < 16) cap[4'(cap_len)] = tx_out;
            cap_len++;
        end else begin
            if (tx_out !== 1'b1) idle_bad++;
            if (cap_len > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", cap, 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] e;
                    int          l;
                    e = exp_q.pop_front();
                    l = exp_len_q.pop_front();
                    check("busy_len", cap_len, l);
                    check("frame_bits", cap, e);
                end
                frames_done++;
                seen_frame = 1;
                gap = 0;
                cap_len = 0;
            end
            gap++;
        end
    end

    // Driver tasks
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic expect_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        logic [15:0] b;
        int          l;
        build_frame(d, pe, pt, b, l);
        exp_q.push_back(b);
        exp_len_q.push_back(l);
        n_sent++;
    endtask

    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
        wait_idle();
        data_in = d;
        par_en = pe;
        par_type = pt;
        data_valid = 1'b1;
        expect_frame(d, pe, pt);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data_in = W'($urandom);
        par_en = 1'(($urandom));
        par_type = 1'(($urandom));
    endtask

    logic [W-1:0] held_bytes[3] = '{8'h00, 8'hFF, 8'h3C};

    initial begin
        int bad_tx;
        int bad_busy;

        // Async reset with no clock edge in between.
        #2 rst_n = 1'b0;
        #1;
        check("reset_tx", tx_out, 1);
        check("reset_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        bad_tx = 0;
        bad_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_out !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("idle20_tx", bad_tx, 0);
        check("idle20_busy", bad_busy, 0);

        // Directed frames
        send(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        send(8'hA5, 1'b1, 1'b1);
        send(8'h01, 1'b1, 1'b0);

        // valid held high across three frames
        wait_idle();
        data_valid = 1'b1;
        par_en = 1'b0;
        data_in = held_bytes[0];
        expect_frame(held_bytes[0], 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 1; i < 3; i++) begin
            data_in = held_bytes[i];
            expect_frame(held_bytes[i], 1'b0, 1'b0);
            wait_idle();
            check_gap = 1;
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
        wait_idle();
        check_gap = 0;

        // Request while busy is dropped; mid-frame input changes are ignored.
        send(8'h0F, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        data_in = 8'h55;
        par_type = 1'b1;
        par_en = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_in = 8'hF0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("ignored_pending", exp_q.size(), 0);

        // Reset mid-DATA on an all-zero byte so the line is low when reset hits.
        send(8'h00, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_reset_tx", tx_out, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midframe_reset_tx", tx_out, 1);
        check("midframe_reset_busy", busy, 0);
        exp_q.delete();
        exp_len_q.delete();
        n_sent--;
        @(negedge clk);
        #2 rst_n = 1'b1;

        send(8'hA5, 1'b1, 1'b1);

        // Random frames with random idle spacing
        for (int i = 0; i < 20; i++) begin
            send(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("idle_line_level", idle_bad, 0);
        check("pending_frames", exp_q.size(), 0);
        check("frames_seen", frames_done, n_sent);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
